// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding
// and the handshake bytes returned to the host over the UART.
package loader_pkg;

    typedef enum logic [2:0] {
        S_SIZE = 3'd0,
        S_LOAD = 3'd1,
        S_ACK  = 3'd2,
        S_NAK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } loader_state_t;

    localparam logic [7:0] LOADER_ACK_BYTE = 8'hAA;
    localparam logic [7:0] LOADER_NAK_BYTE = 8'h55;

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader. The first assembled UART word is a program
// length N. The next N words are written to instruction memory at
// consecutive addresses from BASE_ADDR, with the address wrapping modulo
// the memory size. Once the load ends, a one-byte ACK is sent, or a NAK
// if N was larger than the memory. After an ACK the core is released from
// reset.
module prog_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 14,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] ACK_BYTE  = LOADER_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE  = LOADER_NAK_BYTE
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_rstn
);

    // Largest legal length: exactly fills the memory.
    localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [31:0]       CAP_WORD  = 32'(CAPACITY);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   REMAIN_1  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_1    = ADDR_W'(1);

    loader_state_t     state_q, state_d;
    // The remaining count never exceeds CAPACITY, so ADDR_W+1 bits suffice.
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q, load_err_d;
    logic              cpu_rstn_q, cpu_rstn_d;

    // Next-state and next-output logic for the loader FSM.
    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        addr_cnt_d   = addr_cnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        // Status levels follow the state with one cycle of delay. This puts
        // the release of the core one cycle after the tx_start pulse.
        load_done_d  = (state_q == S_DONE);
        load_err_d   = (state_q == S_ERR);
        cpu_rstn_d   = (state_q == S_DONE);

        case (state_q)
            S_SIZE: begin
                if (word_valid) begin
                    remain_d   = word_in[ADDR_W:0];
                    addr_cnt_d = BASE;
                    if (word_in == 32'd0) begin
                        state_d = S_ACK;
                    end else if (word_in > CAP_WORD) begin
                        state_d = S_NAK;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_SIZE;
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = addr_cnt_q;
                    imem_wdata_d = word_in;
                    addr_cnt_d   = addr_cnt_q + ADDR_1;
                    remain_d     = remain_q - REMAIN_1;
                    if (remain_q == REMAIN_1) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_ACK: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_NAK: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = NAK_BYTE;
                    state_d    = S_ERR;
                end else begin
                    state_d = S_NAK;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_SIZE;
        endcase
    end

    // State and registered outputs. The reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_SIZE;
            remain_q     <= '0;
            addr_cnt_q   <= BASE;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE;
            imem_wdata_q <= 32'd0;
            tx_data_q    <= 8'd0;
            tx_start_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
            cpu_rstn_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            addr_cnt_q   <= addr_cnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
            cpu_rstn_q   <= cpu_rstn_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign cpu_rstn   = cpu_rstn_q;

endmodule
